// File: rtl/counter_update_sched_if.sv
// Request, SRAM and gencounter signals of counter_update_sched bundled as one interface.
// master = environment side (requesters, SRAM, gencounter); slave = the scheduler.
interface counter_update_sched_if #(
    parameter int C_ID_WIDTH      = 12,
    parameter int C_COUNTER_WIDTH = 20,
    parameter int C_PD_WIDTH      = 32
);
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [C_ID_WIDTH-1:0]      pkt_id;
    logic [C_PD_WIDTH-1:0]      pkt_pd;

    logic                       cfg_valid;
    logic                       cfg_ready;
    logic                       cfg_op;
    logic [C_ID_WIDTH-1:0]      cfg_id;
    logic                       cfg_rd_valid;
    logic [C_COUNTER_WIDTH-1:0] cfg_rd_data;

    logic                       mem_rd_en;
    logic [C_ID_WIDTH-1:0]      mem_rd_addr;
    logic [C_COUNTER_WIDTH-1:0] mem_rd_data;
    logic                       mem_wr_en;
    logic [C_ID_WIDTH-1:0]      mem_wr_addr;
    logic [C_COUNTER_WIDTH-1:0] mem_wr_data;

    logic                       gen_counter_valid;
    logic [C_COUNTER_WIDTH-1:0] gen_counter_value;
    logic                       gen_pd_valid;
    logic [C_PD_WIDTH-1:0]      gen_pd_value;
    logic [C_ID_WIDTH-1:0]      gen_id_value;
    logic                       gen_update_valid;
    logic [C_COUNTER_WIDTH-1:0] gen_counter_new;
    logic [C_ID_WIDTH-1:0]      gen_id_next;

    logic                       err_timeout;
    logic                       err_id_mismatch;

    modport master (
        output pkt_valid, pkt_id, pkt_pd,
        output cfg_valid, cfg_op, cfg_id,
        output mem_rd_data,
        output gen_update_valid, gen_counter_new, gen_id_next,
        input  pkt_ready, cfg_ready, cfg_rd_valid, cfg_rd_data,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  gen_counter_valid, gen_counter_value, gen_pd_valid, gen_pd_value, gen_id_value,
        input  err_timeout, err_id_mismatch
    );

    modport slave (
        input  pkt_valid, pkt_id, pkt_pd,
        input  cfg_valid, cfg_op, cfg_id,
        input  mem_rd_data,
        input  gen_update_valid, gen_counter_new, gen_id_next,
        output pkt_ready, cfg_ready, cfg_rd_valid, cfg_rd_data,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output gen_counter_valid, gen_counter_value, gen_pd_valid, gen_pd_value, gen_id_value,
        output err_timeout, err_id_mismatch
    );
endinterface

// File: rtl/counter_update_sched.sv
// Round-robin read-modify-write scheduler for per-flow counters in a 1-cycle SRAM, via gencounter.
// Optional COUNTER_SAT_EN: an all-ones counter is rewritten unchanged instead of wrapping.
//
// state | meaning
// IDLE  | arbitrate pkt/cfg requesters, accept one operation
// RD    | SRAM read of latched id
// CALC  | hand SRAM value to gencounter (exact +1 or probabilistic request)
// WAIT  | wait for gencounter response, write back or flag error / timeout
// RESP  | capture SRAM value as cfg READ response
// CLR   | write zero to latched id
module counter_update_sched #(
    parameter int C_ID_WIDTH      = 12,
    parameter int C_COUNTER_WIDTH = 20,
    parameter int C_PD_WIDTH      = 32,
    parameter int SMALL_THRESH    = 16,
    parameter int RESP_TIMEOUT    = 4
) (
    input logic                   clk,
    input logic                   rst,
    counter_update_sched_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, CALC, WAIT, RESP, CLR} state_t;

    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TW-1:0]              TMR_LOAD = TW'(RESP_TIMEOUT - 1);
    localparam logic [C_COUNTER_WIDTH-1:0] THRESH   = C_COUNTER_WIDTH'(SMALL_THRESH);
    localparam logic [C_COUNTER_WIDTH-1:0] CNT_ONE  = C_COUNTER_WIDTH'(1);

    state_t                     state;
    state_t                     state_nxt;
    logic [C_ID_WIDTH-1:0]      id_q;
    logic [C_PD_WIDTH-1:0]      pd_q;
    logic                       src_cfg_q;
    logic                       rr_ptr_cfg;
    logic [TW-1:0]              tmr_q;
    logic                       cfg_rd_valid_q;
    logic [C_COUNTER_WIDTH-1:0] cfg_rd_data_q;
    logic                       err_timeout_q;
    logic                       err_id_mismatch_q;

    logic                       grant_pkt;
    logic                       grant_cfg;
    logic                       accept_pkt;
    logic                       accept_cfg;
    logic                       sat_hit;
    logic                       small_hit;
    logic                       timeout_hit;
    logic                       mismatch_hit;

    logic                       pkt_ready;
    logic                       cfg_ready;
    logic                       mem_rd_en;
    logic [C_ID_WIDTH-1:0]      mem_rd_addr;
    logic                       mem_wr_en;
    logic [C_ID_WIDTH-1:0]      mem_wr_addr;
    logic [C_COUNTER_WIDTH-1:0] mem_wr_data;
    logic                       gen_counter_valid;
    logic [C_COUNTER_WIDTH-1:0] gen_counter_value;
    logic                       gen_pd_valid;
    logic [C_PD_WIDTH-1:0]      gen_pd_value;
    logic [C_ID_WIDTH-1:0]      gen_id_value;

    // rr_ptr_cfg set means cfg wins the next tie; cleared by reset so pkt goes first.
    assign grant_pkt  = bus.pkt_valid && (!bus.cfg_valid || !rr_ptr_cfg);
    assign grant_cfg  = bus.cfg_valid && (!bus.pkt_valid ||  rr_ptr_cfg);
    assign accept_pkt = (state == IDLE) && grant_pkt;
    assign accept_cfg = (state == IDLE) && grant_cfg;

    assign small_hit = (bus.mem_rd_data < THRESH);
`ifdef COUNTER_SAT_EN
    assign sat_hit = (bus.mem_rd_data == '1);
`else
    assign sat_hit = 1'b0;
`endif

    always_comb begin
        state_nxt         = state;
        pkt_ready         = 1'b0;
        cfg_ready         = 1'b0;
        mem_rd_en         = 1'b0;
        mem_rd_addr       = '0;
        mem_wr_en         = 1'b0;
        mem_wr_addr       = '0;
        mem_wr_data       = '0;
        gen_counter_valid = 1'b0;
        gen_counter_value = '0;
        gen_pd_valid      = 1'b0;
        gen_pd_value      = '0;
        gen_id_value      = '0;
        timeout_hit       = 1'b0;
        mismatch_hit      = 1'b0;
        case (state)
            IDLE: begin
                pkt_ready = grant_pkt;
                cfg_ready = grant_cfg;
                if (grant_pkt) begin
                    state_nxt = RD;
                end else if (grant_cfg) begin
                    state_nxt = bus.cfg_op ? CLR : RD;
                end
            end
            RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = id_q;
                state_nxt   = src_cfg_q ? RESP : CALC;
            end
            CALC: begin
                gen_id_value = id_q;
                if (sat_hit) begin
                    gen_counter_valid = 1'b1;
                    gen_counter_value = bus.mem_rd_data;
                end else if (small_hit) begin
                    gen_counter_valid = 1'b1;
                    gen_counter_value = bus.mem_rd_data + CNT_ONE;
                end else begin
                    gen_pd_valid      = 1'b1;
                    gen_pd_value      = pd_q;
                    gen_counter_value = bus.mem_rd_data;
                end
                state_nxt = WAIT;
            end
            WAIT: begin
                // A response arriving in the last allowed cycle still wins over the timeout.
                if (bus.gen_update_valid) begin
                    if (bus.gen_id_next == id_q) begin
                        mem_wr_en   = 1'b1;
                        mem_wr_addr = id_q;
                        mem_wr_data = bus.gen_counter_new;
                    end else begin
                        mismatch_hit = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (tmr_q == '0) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            CLR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = id_q;
                mem_wr_data = '0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            id_q              <= '0;
            pd_q              <= '0;
            src_cfg_q         <= 1'b0;
            rr_ptr_cfg        <= 1'b0;
            tmr_q             <= '0;
            cfg_rd_valid_q    <= 1'b0;
            cfg_rd_data_q     <= '0;
            err_timeout_q     <= 1'b0;
            err_id_mismatch_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_pkt) begin
                id_q       <= bus.pkt_id;
                pd_q       <= bus.pkt_pd;
                src_cfg_q  <= 1'b0;
                rr_ptr_cfg <= 1'b1;
            end else if (accept_cfg) begin
                id_q       <= bus.cfg_id;
                src_cfg_q  <= 1'b1;
                rr_ptr_cfg <= 1'b0;
            end
            // Down-counter: WAIT lasts at most RESP_TIMEOUT cycles, expiring at zero.
            if (state == CALC) begin
                tmr_q <= TMR_LOAD;
            end else if ((state == WAIT) && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TW'(1);
            end
            cfg_rd_valid_q <= (state == RESP);
            if (state == RESP) begin
                cfg_rd_data_q <= bus.mem_rd_data;
            end
            err_timeout_q     <= timeout_hit;
            err_id_mismatch_q <= mismatch_hit;
        end
    end

    assign bus.pkt_ready         = pkt_ready;
    assign bus.cfg_ready         = cfg_ready;
    assign bus.cfg_rd_valid      = cfg_rd_valid_q;
    assign bus.cfg_rd_data       = cfg_rd_data_q;
    assign bus.mem_rd_en         = mem_rd_en;
    assign bus.mem_rd_addr       = mem_rd_addr;
    assign bus.mem_wr_en         = mem_wr_en;
    assign bus.mem_wr_addr       = mem_wr_addr;
    assign bus.mem_wr_data       = mem_wr_data;
    assign bus.gen_counter_valid = gen_counter_valid;
    assign bus.gen_counter_value = gen_counter_value;
    assign bus.gen_pd_valid      = gen_pd_valid;
    assign bus.gen_pd_value      = gen_pd_value;
    assign bus.gen_id_value      = gen_id_value;
    assign bus.err_timeout       = err_timeout_q;
    assign bus.err_id_mismatch   = err_id_mismatch_q;

endmodule
